// File: rtl/regfile_writeback_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_writeback_pkg
//  Description : Shared instruction definitions for the writeback slice:
//                data/address widths, result-buffer depth and opcode set.
//  Revision    : 1.0  initial release
// ============================================================================
package regfile_writeback_pkg;

    localparam int C_LEN_REG     = 32;
    localparam int C_LEN_REGADDR = 4;
    localparam int C_FIFO_DEPTH  = 2;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_ADD  = 4'h1,
        OP_ADDC = 4'h2,
        OP_SUB  = 4'h3,
        OP_LD   = 4'h4,
        OP_ST   = 4'h5
    } opcode_e;

endpackage
`default_nettype wire

// File: rtl/regfile_writeback_if.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_writeback_if
//  Description : Execute-result handshake channel into the writeback stage.
//  Revision    : 1.0  initial release
// ============================================================================
interface regfile_writeback_if
    import regfile_writeback_pkg::*;
#(
    parameter int LEN_REG     = C_LEN_REG,
    parameter int LEN_REGADDR = C_LEN_REGADDR
);
    logic                   ex_valid;
    logic                   ex_ready;
    logic [LEN_REGADDR-1:0] ex_addr;
    logic [LEN_REG-1:0]     ex_data;
    logic                   ex_we;
    logic                   ex_carry;
    logic                   ex_cwe;

    // Execute unit drives results, writeback answers with ready
    modport master (
        output ex_valid, ex_addr, ex_data, ex_we, ex_carry, ex_cwe,
        input  ex_ready
    );

    modport slave (
        input  ex_valid, ex_addr, ex_data, ex_we, ex_carry, ex_cwe,
        output ex_ready
    );
endinterface
`default_nettype wire

// File: rtl/regfile_writeback_result_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : result_fifo
//  Description : 2-entry in-order result buffer. Both slots are visible so
//                the register file can bypass pending writes; o_head is the
//                oldest entry, o_tail the youngest valid entry.
//  Revision    : 1.0  initial release
// ============================================================================
module result_fifo
    import regfile_writeback_pkg::*;
#(
    parameter int LEN_REG     = C_LEN_REG,
    parameter int LEN_REGADDR = C_LEN_REGADDR
) (
    input  wire logic                   clk,
    input  wire logic                   rst_n,
    input  wire logic                   i_push,
    input  wire logic                   i_pop,
    input  wire logic [LEN_REGADDR-1:0] i_addr,
    input  wire logic [LEN_REG-1:0]     i_data,
    input  wire logic                   i_we,
    input  wire logic                   i_carry,
    input  wire logic                   i_cwe,
    output logic                        o_head,
    output logic                        o_tail,
    output logic [1:0]                  o_count,
    output logic [LEN_REGADDR-1:0]      o_addr  [C_FIFO_DEPTH],
    output logic [LEN_REG-1:0]          o_data  [C_FIFO_DEPTH],
    output logic                        o_we    [C_FIFO_DEPTH],
    output logic                        o_carry [C_FIFO_DEPTH],
    output logic                        o_cwe   [C_FIFO_DEPTH]
);

    logic                   r_head;
    logic [1:0]             r_count;
    logic [LEN_REGADDR-1:0] r_addr  [C_FIFO_DEPTH];
    logic [LEN_REG-1:0]     r_data  [C_FIFO_DEPTH];
    logic                   r_we    [C_FIFO_DEPTH];
    logic                   r_carry [C_FIFO_DEPTH];
    logic                   r_cwe   [C_FIFO_DEPTH];
    logic                   w_wr_idx;

    // Next free slot; when full the push lands in the slot being popped
    assign w_wr_idx = r_head ^ r_count[0];

    // Slot storage, head pointer and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= 1'b0;
            r_count <= 2'd0;
            for (int i = 0; i < C_FIFO_DEPTH; i++) begin
                r_addr[i]  <= '0;
                r_data[i]  <= '0;
                r_we[i]    <= 1'b0;
                r_carry[i] <= 1'b0;
                r_cwe[i]   <= 1'b0;
            end
        end else begin
            if (i_push) begin
                r_addr[w_wr_idx]  <= i_addr;
                r_data[w_wr_idx]  <= i_data;
                r_we[w_wr_idx]    <= i_we;
                r_carry[w_wr_idx] <= i_carry;
                r_cwe[w_wr_idx]   <= i_cwe;
            end
            if (i_pop) begin
                r_head <= ~r_head;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_head;
    assign o_tail  = r_head ^ (r_count == 2'd2);
    assign o_count = r_count;
    assign o_addr  = r_addr;
    assign o_data  = r_data;
    assign o_we    = r_we;
    assign o_carry = r_carry;
    assign o_cwe   = r_cwe;

endmodule
`default_nettype wire

// File: rtl/regfile_writeback.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_writeback
//  Description : Register file with a 2-entry execute-result buffer, a
//                priority load-return write port, read bypass and carry flag.
//  Revision    : 1.0  initial release
// ============================================================================
module regfile_writeback
    import regfile_writeback_pkg::*;
#(
    parameter int LEN_REG     = C_LEN_REG,
    parameter int LEN_REGADDR = C_LEN_REGADDR
) (
    input  wire logic                   clk,
    input  wire logic                   rst_n,
    regfile_writeback_if.slave          ex,
    input  wire logic                   ld_valid,
    input  wire logic [LEN_REGADDR-1:0] ld_addr,
    input  wire logic [LEN_REG-1:0]     ld_data,
    input  wire logic [LEN_REGADDR-1:0] rd_addr,
    input  wire logic [LEN_REGADDR-1:0] rs_addr,
    output logic [LEN_REG-1:0]          data_rd,
    output logic [LEN_REG-1:0]          data_rs,
    output logic                        carry_i,
    output logic [1:0]                  pending
);

    localparam int C_NUM_REGS = 2 ** LEN_REGADDR;

    logic                   w_head;
    logic                   w_tail;
    logic [1:0]             w_count;
    logic [LEN_REGADDR-1:0] w_addr  [C_FIFO_DEPTH];
    logic [LEN_REG-1:0]     w_data  [C_FIFO_DEPTH];
    logic                   w_we    [C_FIFO_DEPTH];
    logic                   w_carry [C_FIFO_DEPTH];
    logic                   w_cwe   [C_FIFO_DEPTH];

    logic                   w_old_v;
    logic                   w_young_v;
    logic                   w_drain;
    logic                   w_ready;
    logic                   w_push;
    logic                   w_ld_conflict;

    logic [LEN_REG-1:0]     r_regs [C_NUM_REGS];
    logic                   r_carry;

    // Load returns own the single write port; the buffer drains otherwise
    assign w_old_v   = (w_count != 2'd0);
    assign w_young_v = (w_count == 2'd2);
    assign w_drain   = w_old_v && !ld_valid;
    assign w_ready   = !w_young_v || w_drain;
    assign w_push    = ex.ex_valid && w_ready;
    assign ex.ex_ready = w_ready;
    assign pending   = w_count;

    result_fifo #(
        .LEN_REG     (LEN_REG),
        .LEN_REGADDR (LEN_REGADDR)
    ) u_result_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_drain),
        .i_addr  (ex.ex_addr),
        .i_data  (ex.ex_data),
        .i_we    (ex.ex_we),
        .i_carry (ex.ex_carry),
        .i_cwe   (ex.ex_cwe),
        .o_head  (w_head),
        .o_tail  (w_tail),
        .o_count (w_count),
        .o_addr  (w_addr),
        .o_data  (w_data),
        .o_we    (w_we),
        .o_carry (w_carry),
        .o_cwe   (w_cwe)
    );

    // Newest value of a register: youngest pending, older pending, load, array
    function automatic logic [LEN_REG-1:0] f_read(input logic [LEN_REGADDR-1:0] a);
        if (w_young_v && w_we[w_tail] && (w_addr[w_tail] == a)) begin
            return w_data[w_tail];
        end else if (w_old_v && w_we[w_head] && (w_addr[w_head] == a)) begin
            return w_data[w_head];
        end else if (ld_valid && (ld_addr == a)) begin
            return ld_data;
        end else begin
            return r_regs[a];
        end
    endfunction

    // Combinational read ports with bypass
    always_comb begin
        data_rd = f_read(rd_addr);
        data_rs = f_read(rs_addr);
    end

    // Architectural carry as seen by the next add, including pending updates
    always_comb begin
        carry_i = r_carry;
        if (w_young_v && w_cwe[w_tail]) begin
            carry_i = w_carry[w_tail];
        end else if (w_old_v && w_cwe[w_head]) begin
            carry_i = w_carry[w_head];
        end
    end

    // Register array and carry flag update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < C_NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
            r_carry <= 1'b0;
        end else if (ld_valid) begin
            r_regs[ld_addr] <= ld_data;
        end else if (w_drain) begin
            if (w_we[w_head]) begin
                r_regs[w_addr[w_head]] <= w_data[w_head];
            end
            if (w_cwe[w_head]) begin
                r_carry <= w_carry[w_head];
            end
        end
    end

    // A load must never target a register with a write still buffered
    assign w_ld_conflict = ld_valid &&
        ((w_old_v   && w_we[w_head] && (w_addr[w_head] == ld_addr)) ||
         (w_young_v && w_we[w_tail] && (w_addr[w_tail] == ld_addr)));

    a_no_ld_conflict : assert property (@(posedge clk) disable iff (!rst_n) !w_ld_conflict);

endmodule
`default_nettype wire

// File: tb/tb_regfile_writeback.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_writeback
//  Description : Self-checking bench for regfile_writeback with directed
//                scenarios and randomized traffic against a queue model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_regfile_writeback;

    logic        clk;
    logic        rst_n;
    logic        ld_valid;
    logic [3:0]  ld_addr;
    logic [31:0] ld_data;
    logic [3:0]  rd_addr;
    logic [3:0]  rs_addr;
    logic [31:0] data_rd;
    logic [31:0] data_rs;
    logic        carry_i;
    logic [1:0]  pending;

    int n_tests = 0;
    int n_fail  = 0;

    regfile_writeback_if ex_if ();

    regfile_writeback dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ex       (ex_if),
        .ld_valid (ld_valid),
        .ld_addr  (ld_addr),
        .ld_data  (ld_data),
        .rd_addr  (rd_addr),
        .rs_addr  (rs_addr),
        .data_rd  (data_rd),
        .data_rs  (data_rs),
        .carry_i  (carry_i),
        .pending  (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: in-order queue of results, register array, carry flag
    typedef struct {
        logic [3:0]  addr;
        logic [31:0] data;
        bit          we;
        bit          c;
        bit          cwe;
    } ent_t;

    ent_t        q[$];
    logic [31:0] m_regs [16];
    bit          m_carry;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [3:0] a, input bit lv,
                                           input logic [3:0] la, input logic [31:0] ldd);
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].we && q[i].addr == a) return q[i].data;
        end
        if (lv && la == a) return ldd;
        return m_regs[a];
    endfunction

    function automatic bit m_conflict(input logic [3:0] a);
        foreach (q[i]) if (q[i].we && q[i].addr == a) return 1'b1;
        return 1'b0;
    endfunction

    task automatic m_clear();
        q.delete();
        for (int i = 0; i < 16; i++) m_regs[i] = 32'h0;
        m_carry = 1'b0;
    endtask

    // One clock cycle: drive, check all outputs, advance the model
    task automatic step(input bit v, input logic [3:0] a, input logic [31:0] d,
                        input bit we, input bit c, input bit cwe,
                        input bit lv, input logic [3:0] la, input logic [31:0] ldd,
                        input logic [3:0] ra, input logic [3:0] sa);
        bit   drain, exp_ready, push, exp_carry;
        ent_t e;
        @(negedge clk);
        ex_if.ex_valid = v;  ex_if.ex_addr = a;   ex_if.ex_data = d;
        ex_if.ex_we    = we; ex_if.ex_carry = c;  ex_if.ex_cwe  = cwe;
        ld_valid = lv; ld_addr = la; ld_data = ldd;
        rd_addr = ra; rs_addr = sa;
        #1;
        drain     = (q.size() > 0) && !lv;
        exp_ready = (q.size() < 2) || drain;
        push      = v && exp_ready;
        exp_carry = m_carry;
        foreach (q[i]) if (q[i].cwe) exp_carry = q[i].c;
        check_val("ex_ready", 32'(ex_if.ex_ready), 32'(exp_ready));
        check_val("pending",  32'(pending),        32'(q.size()));
        check_val("data_rd",  data_rd,             m_read(ra, lv, la, ldd));
        check_val("data_rs",  data_rs,             m_read(sa, lv, la, ldd));
        check_val("carry_i",  32'(carry_i),        32'(exp_carry));
        if (lv) begin
            m_regs[la] = ldd;
        end else if (drain) begin
            e = q.pop_front();
            if (e.we)  m_regs[e.addr] = e.data;
            if (e.cwe) m_carry = e.c;
        end
        if (push) begin
            e.addr = a; e.data = d; e.we = we; e.c = c; e.cwe = cwe;
            q.push_back(e);
        end
    endtask

    task automatic idle(input logic [3:0] ra, input logic [3:0] sa);
        step(1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0, ra, sa);
    endtask

    // Asynchronous reset applied between clock edges
    task automatic do_reset();
        @(negedge clk);
        ex_if.ex_valid = 1'b0;
        ld_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        m_clear();
        check_val("rst_pending",  32'(pending),        32'(q.size()));
        check_val("rst_ex_ready", 32'(ex_if.ex_ready), 32'h1);
        check_val("rst_carry",    32'(carry_i),        32'(m_carry));
        check_val("rst_data_rd",  data_rd,             m_regs[rd_addr]);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [3:0] la;
        rst_n = 1'b0;
        ex_if.ex_valid = 1'b0; ex_if.ex_addr = '0; ex_if.ex_data = '0;
        ex_if.ex_we = 1'b0; ex_if.ex_carry = 1'b0; ex_if.ex_cwe = 1'b0;
        ld_valid = 1'b0; ld_addr = '0; ld_data = '0;
        rd_addr = '0; rs_addr = '0;
        m_clear();
        do_reset();

        // Single write becomes visible through bypass, then lands in r3
        step(1, 4'd3, 32'h12345678, 1, 0, 0, 0, 4'd0, 32'h0, 4'd3, 4'd0);
        idle(4'd3, 4'd3);
        idle(4'd3, 4'd0);

        // Load held three cycles: two results buffered, third refused
        step(1, 4'd1, 32'hA1, 1, 0, 0, 1, 4'd7, 32'h77, 4'd1, 4'd7);
        step(1, 4'd2, 32'hA2, 1, 0, 0, 1, 4'd7, 32'h78, 4'd2, 4'd1);
        step(1, 4'd4, 32'hA4, 1, 0, 0, 1, 4'd8, 32'h88, 4'd4, 4'd8);
        idle(4'd1, 4'd2);
        idle(4'd2, 4'd7);
        idle(4'd8, 4'd4);

        // Two queued writes to r5: the younger value is visible
        step(1, 4'd5, 32'h1, 1, 0, 0, 1, 4'd9, 32'h99, 4'd0, 4'd5);
        step(1, 4'd5, 32'h2, 1, 0, 0, 1, 4'd9, 32'h9A, 4'd9, 4'd5);
        idle(4'd5, 4'd5);
        idle(4'd5, 4'd5);
        idle(4'd9, 4'd5);

        // Carry updates queued in order
        step(1, 4'd0, 32'h0, 0, 0, 1, 1, 4'd6, 32'h66, 4'd0, 4'd0);
        step(1, 4'd0, 32'h0, 0, 1, 1, 1, 4'd6, 32'h67, 4'd6, 4'd0);
        idle(4'd0, 4'd6);
        idle(4'd0, 4'd0);
        idle(4'd0, 4'd0);

        // Full buffer with push and drain together keeps occupancy and order
        step(1, 4'd10, 32'hB0, 1, 0, 0, 1, 4'd2, 32'h22, 4'd10, 4'd2);
        step(1, 4'd11, 32'hB1, 1, 0, 0, 1, 4'd2, 32'h23, 4'd11, 4'd10);
        step(1, 4'd12, 32'hB2, 1, 0, 0, 0, 4'd0, 32'h0,  4'd10, 4'd11);
        step(1, 4'd10, 32'hB3, 1, 0, 0, 0, 4'd0, 32'h0,  4'd10, 4'd12);
        idle(4'd10, 4'd11);
        idle(4'd12, 4'd10);
        idle(4'd10, 4'd12);

        // Reset with a full buffer discards it
        step(1, 4'd13, 32'hC0, 1, 1, 1, 1, 4'd1, 32'h11, 4'd13, 4'd1);
        step(1, 4'd14, 32'hC1, 1, 0, 0, 1, 4'd1, 32'h12, 4'd14, 4'd13);
        do_reset();
        idle(4'd13, 4'd14);
        idle(4'd1, 4'd3);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            bit lv;
            lv = ($urandom_range(0, 3) == 0);
            la = 4'($urandom_range(0, 15));
            while (m_conflict(la)) la = la + 4'd1;
            step(bit'($urandom_range(0, 2) != 0), 4'($urandom_range(0, 15)), $urandom,
                 bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 1)),
                 bit'($urandom_range(0, 1)),
                 lv, la, $urandom,
                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        end

        for (int i = 0; i < 16; i++) idle(4'(i), 4'(15 - i));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
